// File: rtl/btt_pkg.sv
// Shared types and default sizes for the branch target table.
package btt_pkg;

  localparam int BTT_ADDR_W = 5;
  localparam int BTT_TGT_W  = 10;
  localparam int BTT_BANKS  = 4;

  typedef enum logic [1:0] {
    BTT_IDLE,
    BTT_LOAD,
    BTT_CLEAR
  } btt_state_e;

  typedef logic [BTT_TGT_W-1:0] btt_target_t;

endpackage

// File: rtl/btt_if.sv
// Lookup and load/clear stream signals of the branch target table.
interface btt_if #(
  parameter int ADDR_W = 5,
  parameter int TGT_W  = 10,
  parameter int BANKS  = 4,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
);
  logic [BANK_W-1:0] bank;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [TGT_W-1:0]  target;
  logic              target_valid;
  logic              hit;
  logic              load_start;
  logic [BANK_W-1:0] load_bank;
  logic [TGT_W-1:0]  load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              clear_start;
  logic              busy;
  logic              load_done;

  modport master (
    output bank, rd, addr, load_start, load_bank, load_data, load_valid,
           load_last, clear_start,
    input  target, target_valid, hit, load_ready, busy, load_done
  );

  modport slave (
    input  bank, rd, addr, load_start, load_bank, load_data, load_valid,
           load_last, clear_start,
    output target, target_valid, hit, load_ready, busy, load_done
  );
endinterface

// File: rtl/btt_storage.sv
// Banked target array with per-entry valid bits and a registered read port.
// With BTT_BYPASS_EN defined, a same-cycle write to the read entry is forwarded.
module btt_storage #(
  parameter int ADDR_W = 5,
  parameter int TGT_W  = 10,
  parameter int BANKS  = 4,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [BANK_W-1:0] i_wbank,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [TGT_W-1:0]  i_wdata,
  input  logic              i_clr,
  input  logic [BANK_W-1:0] i_clr_bank,
  input  logic              i_rd,
  input  logic [BANK_W-1:0] i_rbank,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [TGT_W-1:0]  o_rdata,
  output logic              o_rvalid,
  output logic              o_hit
);
  localparam int DEPTH = 2**ADDR_W;

  logic [TGT_W-1:0]  r_data [BANKS][DEPTH];
  logic [DEPTH-1:0]  r_valid [BANKS];

  logic              w_wok;
  logic              w_rok;
  logic [BANK_W-1:0] w_ridx;
  logic              w_hit_raw;
  logic              w_hit;
  logic [TGT_W-1:0]  w_rdata;

  // Bank numbers beyond BANKS-1 never write and always miss.
  assign w_wok  = ({1'b0, i_wbank} < (BANK_W+1)'(BANKS));
  assign w_rok  = ({1'b0, i_rbank} < (BANK_W+1)'(BANKS));
  assign w_ridx = w_rok ? i_rbank : '0;

  always_ff @(posedge i_clk) begin
    if (i_we && w_wok) begin
      r_data[i_wbank][i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        r_valid[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (i_clr && (i_clr_bank == BANK_W'(b))) begin
          r_valid[b] <= '0;
        end else if (i_we && (i_wbank == BANK_W'(b))) begin
          r_valid[b][i_waddr] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hit_raw = w_rok & r_valid[w_ridx][i_raddr];
`ifdef BTT_BYPASS_EN
    if (i_we && w_wok && (i_wbank == i_rbank) && (i_waddr == i_raddr)) begin
      w_hit   = 1'b1;
      w_rdata = i_wdata;
    end else begin
      w_hit   = w_hit_raw;
      w_rdata = w_hit_raw ? r_data[w_ridx][i_raddr] : '0;
    end
`else
    w_hit   = w_hit_raw;
    w_rdata = w_hit_raw ? r_data[w_ridx][i_raddr] : '0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_hit    <= 1'b0;
    end else begin
      o_rvalid <= i_rd;
      if (i_rd) begin
        o_rdata <= w_rdata;
        o_hit   <= w_hit;
      end
    end
  end

endmodule

// File: rtl/branch_target_table.sv
// Run-time loadable banked branch-target lookup with load/clear sequencer.
// Optional BTT_BYPASS_EN forwards a same-cycle load beat to a matching lookup.
module branch_target_table
  import btt_pkg::*;
#(
  parameter int ADDR_W = BTT_ADDR_W,
  parameter int TGT_W  = BTT_TGT_W,
  parameter int BANKS  = BTT_BANKS,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input logic  i_clk,
  input logic  i_rst_n,
  btt_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  btt_state_e        r_state;
  btt_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [BANK_W-1:0] r_cptr;
  logic [BANK_W-1:0] w_cptr_nxt;
  logic [BANK_W-1:0] r_load_bank;
  logic [BANK_W-1:0] w_load_bank_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_we;
  logic              w_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= BTT_IDLE;
      r_ptr       <= '0;
      r_cptr      <= '0;
      r_load_bank <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cptr      <= w_cptr_nxt;
      r_load_bank <= w_load_bank_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cptr_nxt      = r_cptr;
    w_load_bank_nxt = r_load_bank;
    w_done_nxt      = 1'b0;
    w_we            = 1'b0;
    w_clr           = 1'b0;
    case (r_state)
      BTT_IDLE: begin
        if (bus.clear_start) begin
          w_state_nxt = BTT_CLEAR;
          w_cptr_nxt  = '0;
        end else if (bus.load_start) begin
          w_state_nxt     = BTT_LOAD;
          w_load_bank_nxt = bus.load_bank;
          w_ptr_nxt       = '0;
        end
      end
      BTT_LOAD: begin
        if (bus.load_valid) begin
          w_we      = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (bus.load_last || (r_ptr == ADDR_W'(DEPTH-1))) begin
            w_state_nxt = BTT_IDLE;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      BTT_CLEAR: begin
        w_clr = 1'b1;
        if (r_cptr == BANK_W'(BANKS-1)) begin
          w_state_nxt = BTT_IDLE;
          w_cptr_nxt  = '0;
        end else begin
          w_cptr_nxt = r_cptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = BTT_IDLE;
      end
    endcase
  end

  assign bus.load_ready = (r_state == BTT_LOAD);
  assign bus.busy       = (r_state != BTT_IDLE);
  assign bus.load_done  = r_done;

  btt_storage #(
    .ADDR_W (ADDR_W),
    .TGT_W  (TGT_W),
    .BANKS  (BANKS),
    .BANK_W (BANK_W)
  ) u_storage (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (w_we),
    .i_wbank    (r_load_bank),
    .i_waddr    (r_ptr),
    .i_wdata    (bus.load_data),
    .i_clr      (w_clr),
    .i_clr_bank (r_cptr),
    .i_rd       (bus.rd),
    .i_rbank    (bus.bank),
    .i_raddr    (bus.addr),
    .o_rdata    (bus.target),
    .o_rvalid   (bus.target_valid),
    .o_hit      (bus.hit)
  );

endmodule
